thread_pc_file: RTL and testbench

- Per-thread program-counter store for the 4-thread barrel pipeline; the write-side counterpart to the round-robin PC selector.
- The selector reads PC0..PC3 and issues one thread per cycle. This block advances the issued thread's PC.
- It also applies branch redirects from execute and tracks per-thread run/halt state.
- All PC outputs are registered and feed the selector directly.

---
 rtl/thread_pc_file.sv | 110 +++++++++++
 tb/tb_thread_pc_file.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/thread_pc_file.sv
`default_nettype none
// ============================================================================
// Module   : thread_pc_file
// Brief    : Per-thread program-counter store for a 4-thread barrel pipeline.
//            Advances the issued thread's PC, applies branch redirects,
//            and tracks per-thread IDLE/RUN/HALT state.
// Revision : 1.0 - initial release
// ============================================================================
module thread_pc_file #(
  parameter int                           INSTMEM_LOG2_DEEP = 8,
  parameter logic [3:0]                   BOOT_MASK         = 4'b0001,
  parameter logic [INSTMEM_LOG2_DEEP-1:0] BOOT_PC           = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_en_i,
  input  logic [1:0]                   issue_tid_i,
  input  logic                         br_valid_i,
  input  logic [1:0]                   br_tid_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0] br_target_i,
  input  logic                         halt_valid_i,
  input  logic [1:0]                   halt_tid_i,
  input  logic                         start_valid_i,
  input  logic [1:0]                   start_tid_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0] start_pc_i,
  output logic [INSTMEM_LOG2_DEEP-1:0] PC0,
  output logic [INSTMEM_LOG2_DEEP-1:0] PC1,
  output logic [INSTMEM_LOG2_DEEP-1:0] PC2,
  output logic [INSTMEM_LOG2_DEEP-1:0] PC3,
  output logic [3:0]                   thread_active_o,
  output logic [3:0]                   pc_wrap_o
);

  localparam int c_W = INSTMEM_LOG2_DEEP;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } thread_state_t;

  // Flattened view of all four PCs so each generate iteration owns one slice.
  logic [4*c_W-1:0] w_pc_flat;

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_thread
      thread_state_t  r_state;
      logic [c_W-1:0] r_pc;
      logic           r_wrap;

      logic w_start;
      logic w_halt;
      logic w_branch;
      logic w_issue;

      // Decode which strobes address this thread.
      always_comb begin
        w_start  = start_valid_i && (start_tid_i == 2'(n));
        w_halt   = halt_valid_i  && (halt_tid_i  == 2'(n));
        w_branch = br_valid_i    && (br_tid_i    == 2'(n));
        w_issue  = issue_en_i    && (issue_tid_i == 2'(n));
      end

      // Prioritised update: start > halt > branch > issue > hold.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_pc    <= BOOT_PC;
          r_state <= BOOT_MASK[n] ? ST_RUN : ST_IDLE;
          r_wrap  <= 1'b0;
        end else begin
          r_wrap <= 1'b0;
          if (w_start) begin
            r_state <= ST_RUN;
            r_pc    <= start_pc_i;
          end else begin
            case (r_state)
              ST_RUN: begin
                if (w_halt) begin
                  r_state <= ST_HALT;
                end else if (w_branch) begin
                  r_pc <= br_target_i;
                end else if (w_issue) begin
                  r_pc   <= r_pc + 1'b1;
                  r_wrap <= &r_pc;
                end
              end
              ST_IDLE, ST_HALT: begin
                r_state <= r_state;
              end
              // Encoding 2'b11 is unreachable; fall back to IDLE if seen.
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      end

      assign w_pc_flat[n*c_W +: c_W] = r_pc;
      assign thread_active_o[n]      = (r_state == ST_RUN);
      assign pc_wrap_o[n]            = r_wrap;
    end
  endgenerate

  assign PC0 = w_pc_flat[0*c_W +: c_W];
  assign PC1 = w_pc_flat[1*c_W +: c_W];
  assign PC2 = w_pc_flat[2*c_W +: c_W];
  assign PC3 = w_pc_flat[3*c_W +: c_W];

endmodule
`default_nettype wire

// File: tb/tb_thread_pc_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_pc_file
// Brief    : Self-checking bench for thread_pc_file: directed scenarios with
//            literal expectations, then randomized traffic against a
//            behavioural model of PC/run state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thread_pc_file;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         issue_en_i, br_valid_i, halt_valid_i, start_valid_i;
  logic [1:0]   issue_tid_i, br_tid_i, halt_tid_i, start_tid_i;
  logic [W-1:0] br_target_i, start_pc_i;
  logic [W-1:0] PC0, PC1, PC2, PC3;
  logic [3:0]   thread_active_o, pc_wrap_o;

  int tests = 0;
  int fails = 0;

  thread_pc_file #(
    .INSTMEM_LOG2_DEEP(W),
    .BOOT_MASK(4'b0001),
    .BOOT_PC(8'h00)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_en_i(issue_en_i), .issue_tid_i(issue_tid_i),
    .br_valid_i(br_valid_i), .br_tid_i(br_tid_i), .br_target_i(br_target_i),
    .halt_valid_i(halt_valid_i), .halt_tid_i(halt_tid_i),
    .start_valid_i(start_valid_i), .start_tid_i(start_tid_i), .start_pc_i(start_pc_i),
    .PC0(PC0), .PC1(PC1), .PC2(PC2), .PC3(PC3),
    .thread_active_o(thread_active_o), .pc_wrap_o(pc_wrap_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: a PC number and a running flag per thread.
  int unsigned m_pc   [4];
  bit          m_run  [4];
  bit  [3:0]   m_wrap;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < 4; t++) begin
        m_pc[t]  = 0;
        m_run[t] = (t == 0);
      end
      m_wrap = 4'b0;
    end else begin
      m_wrap = 4'b0;
      for (int t = 0; t < 4; t++) begin
        if (start_valid_i && start_tid_i == t) begin
          m_run[t] = 1;
          m_pc[t]  = start_pc_i;
        end else if (halt_valid_i && halt_tid_i == t) begin
          m_run[t] = 0;
        end else if (m_run[t] && br_valid_i && br_tid_i == t) begin
          m_pc[t] = br_target_i;
        end else if (m_run[t] && issue_en_i && issue_tid_i == t) begin
          if (m_pc[t] + 1 == 256) begin
            m_pc[t]   = 0;
            m_wrap[t] = 1'b1;
          end else begin
            m_pc[t] = m_pc[t] + 1;
          end
        end
      end
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk_i) begin
    logic [31:0] exp_pcs, act_pcs;
    logic [3:0]  exp_act;
    exp_pcs = {m_pc[3][7:0], m_pc[2][7:0], m_pc[1][7:0], m_pc[0][7:0]};
    act_pcs = {PC3, PC2, PC1, PC0};
    exp_act = {m_run[3], m_run[2], m_run[1], m_run[0]};
    tests += 3;
    if (act_pcs !== exp_pcs) begin
      fails++;
      $display("FAIL model_pcs t=%0t got=%h want=%h", $time, act_pcs, exp_pcs);
    end
    if (thread_active_o !== exp_act) begin
      fails++;
      $display("FAIL model_active t=%0t got=%b want=%b", $time, thread_active_o, exp_act);
    end
    if (pc_wrap_o !== m_wrap) begin
      fails++;
      $display("FAIL model_wrap t=%0t got=%b want=%b", $time, pc_wrap_o, m_wrap);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic clr();
    issue_en_i = 0; issue_tid_i = 0;
    br_valid_i = 0; br_tid_i = 0; br_target_i = 0;
    halt_valid_i = 0; halt_tid_i = 0;
    start_valid_i = 0; start_tid_i = 0; start_pc_i = 0;
  endtask

  // Advance to the next drive point and clear all strobes.
  task automatic nxt();
    @(negedge clk_i);
    clr();
  endtask

  initial begin
    clr();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_pc0", PC0, 8'h00);
    chk("reset_active", thread_active_o, 4'b0001);
    chk("reset_wrap", pc_wrap_o, 4'b0000);
    rst_i = 1'b0;

    // Round-robin issue: only thread 0 runs.
    for (int i = 0; i < 8; i++) begin
      nxt(); issue_en_i = 1; issue_tid_i = 2'(i % 4);
    end
    nxt(); #1;
    chk("rr_pc0", PC0, 8'h02);
    chk("rr_pc123", {PC1, PC2, PC3}, 24'h0);
    chk("rr_active", thread_active_o, 4'b0001);

    // Start thread 1, advance it, then halt it.
    start_valid_i = 1; start_tid_i = 1; start_pc_i = 8'h40;
    for (int i = 0; i < 3; i++) begin
      nxt(); issue_en_i = 1; issue_tid_i = 1;
    end
    nxt(); #1;
    chk("t1_pc", PC1, 8'h43);
    chk("t1_active", thread_active_o, 4'b0011);
    halt_valid_i = 1; halt_tid_i = 1;
    nxt(); issue_en_i = 1; issue_tid_i = 1;
    nxt(); #1;
    chk("t1_halt_pc", PC1, 8'h43);
    chk("t1_halt_active", thread_active_o, 4'b0001);

    // Branch beats issue on the same thread; other threads still update.
    start_valid_i = 1; start_tid_i = 0; start_pc_i = 8'h10;
    nxt(); start_valid_i = 1; start_tid_i = 2; start_pc_i = 8'h05;
    nxt(); issue_en_i = 1; issue_tid_i = 0; br_valid_i = 1; br_tid_i = 0; br_target_i = 8'h80;
    nxt(); #1;
    chk("br_over_issue", PC0, 8'h80);
    start_valid_i = 1; start_tid_i = 0; start_pc_i = 8'h10;
    nxt(); issue_en_i = 1; issue_tid_i = 2; br_valid_i = 1; br_tid_i = 0; br_target_i = 8'h80;
    nxt(); #1;
    chk("br_parallel_pc0", PC0, 8'h80);
    chk("issue_parallel_pc2", PC2, 8'h06);

    // Wrap on thread 3.
    start_valid_i = 1; start_tid_i = 3; start_pc_i = 8'hFF;
    nxt(); issue_en_i = 1; issue_tid_i = 3;
    nxt(); #1;
    chk("wrap_pc3", PC3, 8'h00);
    chk("wrap_pulse", pc_wrap_o, 4'b1000);
    nxt(); #1;
    chk("wrap_clear", pc_wrap_o, 4'b0000);

    // Start beats halt on the same thread.
    start_valid_i = 1; start_tid_i = 2; start_pc_i = 8'h20;
    halt_valid_i = 1; halt_tid_i = 2;
    nxt(); #1;
    chk("start_over_halt_act", thread_active_o[2], 1'b1);
    chk("start_over_halt_pc", PC2, 8'h20);

    // Asynchronous reset mid-cycle with a branch pending.
    br_valid_i = 1; br_tid_i = 0; br_target_i = 8'h33;
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_pcs", {PC3, PC2, PC1, PC0}, 32'h0);
    chk("async_rst_active", thread_active_o, 4'b0001);
    @(negedge clk_i);
    rst_i = 1'b0;
    clr();
    nxt(); #1;
    chk("post_rst_pc0", PC0, 8'h00);
    chk("post_rst_active", thread_active_o, 4'b0001);

    // Randomized traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      issue_en_i    = ($urandom_range(0, 3) != 0);
      issue_tid_i   = 2'($urandom_range(0, 3));
      br_valid_i    = ($urandom_range(0, 3) == 0);
      br_tid_i      = 2'($urandom_range(0, 3));
      br_target_i   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      halt_valid_i  = ($urandom_range(0, 9) == 0);
      halt_tid_i    = 2'($urandom_range(0, 3));
      start_valid_i = ($urandom_range(0, 6) == 0);
      start_tid_i   = 2'($urandom_range(0, 3));
      start_pc_i    = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
    end
    nxt();
    repeat (2) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
